// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
// Optional packet lock is enabled by defining STREAM_MUX_LOCK_EN.
package stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } lock_state_e;

    // Index width for n channels, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake and data bundle between producers, the mux and the consumer.
// master = producer/consumer environment, slave = the multiplexer.
interface stream_mux_rr_if
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12
);
    localparam int CH_W = idx_w(NUM_CH);

    mode_e                      mode;
    logic [CH_W-1:0]            sel;
    logic [NUM_CH-1:0]          in_valid;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic [NUM_CH-1:0]          in_last;
    logic [NUM_CH-1:0]          in_ready;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [CH_W-1:0]            out_ch;
    logic                       out_last;
    logic                       out_ready;

    modport master (
        output mode, sel, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ch, out_last
    );

    modport slave (
        input  mode, sel, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ch, out_last
    );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Rotating-priority encoder: the first requester after ptr wins, wrapping
// from NUM_CH-1 back to 0; ptr itself has the lowest priority.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 8,
    localparam int CH_W   = idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic              gnt_vld,
    output logic [CH_W-1:0]   gnt_idx
);

    // Scan from furthest to nearest so the nearest requester after ptr is the last write.
    always_comb begin
        // NOTE: every output gets a default before any branch, otherwise a latch is inferred.
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_CH]) begin
                gnt_vld = 1'b1;
                gnt_idx = CH_W'((int'(ptr) + k) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// Registered N-channel stream multiplexer with FIXED or round-robin selection.
// Define STREAM_MUX_LOCK_EN to keep a channel granted until its last beat.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave bus
);
    localparam int CH_W = idx_w(NUM_CH);

    logic              load_en;
    logic              grant;
    logic              accept;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   rr_ptr;
    logic              rr_vld;
    logic [CH_W-1:0]   rr_idx;
    logic              locked;
    logic [CH_W-1:0]   lock_ch;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req     (bus.in_valid),
        .ptr     (rr_ptr),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    // The output register can take a new beat when empty or draining this cycle.
    assign load_en = !bus.out_valid || bus.out_ready;

`ifdef STREAM_MUX_LOCK_EN
    lock_state_e     state, state_nxt;
    logic [CH_W-1:0] lock_ch_nxt;
    logic            last_q;

    // Lock state register.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it sits inside the clocked branch and only acts on an edge.
        if (rst) begin
            state   <= ST_IDLE;
            lock_ch <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
        end
    end

    // A non-last beat locks onto its channel; the last beat releases the lock.
    always_comb begin
        state_nxt   = state;
        lock_ch_nxt = lock_ch;
        if (accept) begin
            if (bus.in_last[gnt_idx]) begin
                state_nxt = ST_IDLE;
            end else begin
                state_nxt   = ST_LOCKED;
                lock_ch_nxt = gnt_idx;
            end
        end
    end

    assign locked = (state == ST_LOCKED);

    // End-of-packet flag travels with its beat.
    always_ff @(posedge clk) begin
        if (rst)         last_q <= 1'b0;
        else if (accept) last_q <= bus.in_last[gnt_idx];
    end

    assign bus.out_last = last_q;
`else
    assign locked       = 1'b0;
    assign lock_ch      = '0;
    assign bus.out_last = 1'b0;
`endif

    // Grant selection: lock overrides mode; FIXED grants sel even without valid data.
    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        if (locked) begin
            grant   = 1'b1;
            gnt_idx = lock_ch;
        end else if (bus.mode == MODE_FIXED) begin
            grant   = (int'(bus.sel) < NUM_CH);
            gnt_idx = bus.sel;
        end else begin
            grant   = rr_vld;
            gnt_idx = rr_idx;
        end
    end

    assign accept = grant && load_en && !rst && bus.in_valid[gnt_idx];

    // One-hot ready toward the granted channel, independent of its valid.
    always_comb begin
        bus.in_ready = '0;
        if (grant && load_en && !rst) begin
            bus.in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            rr_ptr        <= CH_W'(NUM_CH - 1);
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= bus.in_data[int'(gnt_idx) * DATA_W +: DATA_W];
            bus.out_ch    <= gnt_idx;
            rr_ptr        <= gnt_idx;
        end else if (load_en) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
